layer_mem_write: RTL

- Parametrised counter/addresser that generates write addresses, channel select and write strobe for a layer-output memory.
- Used for pooling, conv and dense stages alike; one instance per layer output buffer.
- Sits between a layer datapath (producing valid_in) and its output RAM bank(s).
- Supports a configurable pipeline start delay, multi-channel sweeps, pause via enable, restart, and a sticky done flag.

---
 rtl/layer_mem_write.sv | 137 +++++++++++++
 1 files changed

// File: rtl/layer_mem_write.sv
// layer_mem_write: write-address generator for a layer output buffer.
// It sweeps {ch_sel, addr0} across DEPTH words for each of NUM_CH channels.
// A write strobe is issued for every valid datapath result.
// The sweep waits START_DELAY enabled cycles after start before writing.
// A sticky done flag is raised once the last word has been written.
// Optional feature: define LAYER_MEM_WRITE_STALL_CNT_EN to enable the WRITE-state stall counter.
// With that macro undefined, stall_cnt is tied to zero.
module layer_mem_write #(
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int NUM_CH      = 1,
    parameter int START_DELAY = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic              valid_in,
    output logic [ADDR_W-1:0] addr0,
    output logic [CH_W-1:0]   ch_sel,
    output logic              we,
    output logic              done,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {IDLE, DELAY, WRITE, DONE} state_t;

    localparam int DLY_W      = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int DLY_LAST_I = (START_DELAY > 0) ? START_DELAY - 1 : 0;
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_LAST_I[DLY_W-1:0];
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [DLY_W-1:0] dly_cnt;
    logic             addr_last;
    logic             ch_last;

    assign addr_last = (addr0 == ADDR_LAST);
    assign ch_last   = (ch_sel == CH_LAST);

    // State register; start is folded into the next-state logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start wins, otherwise advance only on enabled cycles.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (START_DELAY == 0) ? WRITE : DELAY;
        end else if (enable) begin
            case (state_q)
                IDLE:    state_d = IDLE;
                DELAY:   if (dly_cnt == DLY_LAST) state_d = WRITE;
                WRITE:   if (valid_in && addr_last && ch_last) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Write strobe: only in WRITE, never in the cycle a restart is taken.
    always_comb begin
        we = (state_q == WRITE) && enable && valid_in && !start;
    end

    // Start-delay counter, counting enabled cycles spent in DELAY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_cnt <= '0;
        end else if (start) begin
            dly_cnt <= '0;
        end else if (enable && state_q == DELAY) begin
            if (dly_cnt == DLY_LAST) begin
                dly_cnt <= '0;
            end else begin
                dly_cnt <= dly_cnt + DLY_W'(1);
            end
        end
    end

    // Address/channel sweep; the final write leaves both counters on their last values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr0  <= '0;
            ch_sel <= '0;
        end else if (start) begin
            addr0  <= '0;
            ch_sel <= '0;
        end else if (we) begin
            if (!addr_last) begin
                addr0 <= addr0 + ADDR_W'(1);
            end else if (!ch_last) begin
                addr0  <= '0;
                ch_sel <= ch_sel + CH_W'(1);
            end
        end
    end

    // Sticky done flag, set by the final write and cleared only by start or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else if (start) begin
            done <= 1'b0;
        end else if (we && addr_last && ch_last) begin
            done <= 1'b1;
        end
    end

`ifdef LAYER_MEM_WRITE_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of enabled WRITE cycles in which the datapath had no result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (start) begin
            stall_q <= '0;
        end else if (enable && state_q == WRITE && !valid_in && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
